// File: rtl/mem_req_arbiter.sv
// N-to-1 round-robin arbiter for the req/gnt/rvalid memory protocol; an in-order ID FIFO steers responses back.
// Optional sticky spurious-response flag err_o when MEM_REQ_ARB_ERR_EN is defined.
module mem_req_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDRESS_SIZE    = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
`ifdef MEM_REQ_ARB_ERR_EN
  output logic                               err_o,
`endif
  input  logic [NUM_PORTS*ADDRESS_SIZE-1:0]  in_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    in_data_wdata,
  input  logic [NUM_PORTS-1:0]               in_data_req,
  input  logic [NUM_PORTS-1:0]               in_data_we,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  in_data_be,
  output logic [NUM_PORTS-1:0]               in_data_gnt,
  output logic [NUM_PORTS-1:0]               in_data_rvalid,
  output logic [DATA_WIDTH-1:0]              in_data_rdata,
  output logic [ADDRESS_SIZE-1:0]            out_address,
  output logic [DATA_WIDTH-1:0]              out_data_wdata,
  output logic                               out_data_req,
  output logic                               out_data_we,
  output logic [DATA_WIDTH/8-1:0]            out_data_be,
  input  logic                               out_data_gnt,
  input  logic                               out_data_rvalid,
  input  logic [DATA_WIDTH-1:0]              out_data_rdata
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int BW = DATA_WIDTH / 8;

  logic [PW-1:0] rr_q;
  logic [PW-1:0] winner;
  logic [PW-1:0] id_mem [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [PW-1:0] head;

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem[rd_ptr_q];

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_q) + k) % NUM_PORTS;
      if (!found && in_data_req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign out_data_req = (|in_data_req) && !fifo_full;
  assign push         = out_data_req && out_data_gnt;
  assign pop          = out_data_rvalid && !fifo_empty;

  always_comb begin
    out_address    = '0;
    out_data_wdata = '0;
    out_data_we    = 1'b0;
    out_data_be    = '0;
    if (out_data_req) begin
      out_address    = in_address[winner*ADDRESS_SIZE +: ADDRESS_SIZE];
      out_data_wdata = in_data_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
      out_data_we    = in_data_we[winner];
      out_data_be    = in_data_be[winner*BW +: BW];
    end
  end

  always_comb begin
    in_data_gnt    = '0;
    in_data_rvalid = '0;
    if (push) in_data_gnt[winner] = 1'b1;
    if (pop)  in_data_rvalid[head] = 1'b1;
  end

  assign in_data_rdata = out_data_rdata;

  // Pointer holds while stalled so the selected master's fields stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (push) begin
      if (winner == PW'(NUM_PORTS - 1)) rr_q <= '0;
      else                              rr_q <= winner + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; entries are only read while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= winner;
  end

`ifdef MEM_REQ_ARB_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_o <= 1'b0;
    else if (out_data_rvalid && fifo_empty) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (default parameters: 2 ports, 64-bit, 4 outstanding).
// Also checks err_o when MEM_REQ_ARB_ERR_EN is defined.
module tb_mem_req_arbiter;

  localparam int NP = 2;
  localparam int AS = 64;
  localparam int DW = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP*AS-1:0]   in_address;
  logic [NP*DW-1:0]   in_data_wdata;
  logic [NP-1:0]      in_data_req;
  logic [NP-1:0]      in_data_we;
  logic [NP*DW/8-1:0] in_data_be;
  logic [NP-1:0]      in_data_gnt;
  logic [NP-1:0]      in_data_rvalid;
  logic [DW-1:0]      in_data_rdata;
  logic [AS-1:0]      out_address;
  logic [DW-1:0]      out_data_wdata;
  logic               out_data_req;
  logic               out_data_we;
  logic [DW/8-1:0]    out_data_be;
  logic               out_data_gnt;
  logic               out_data_rvalid;
  logic [DW-1:0]      out_data_rdata;
`ifdef MEM_REQ_ARB_ERR_EN
  logic               err_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [63:0] A0 = 64'h1000;
  localparam logic [63:0] A1 = 64'h2000;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
`ifdef MEM_REQ_ARB_ERR_EN
    .err_o(err_o),
`endif
    .in_address(in_address), .in_data_wdata(in_data_wdata),
    .in_data_req(in_data_req), .in_data_we(in_data_we), .in_data_be(in_data_be),
    .in_data_gnt(in_data_gnt), .in_data_rvalid(in_data_rvalid), .in_data_rdata(in_data_rdata),
    .out_address(out_address), .out_data_wdata(out_data_wdata), .out_data_req(out_data_req),
    .out_data_we(out_data_we), .out_data_be(out_data_be), .out_data_gnt(out_data_gnt),
    .out_data_rvalid(out_data_rvalid), .out_data_rdata(out_data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    in_address      = {A1, A0};
    in_data_wdata   = {64'hBBBB_0001, 64'hAAAA_0000};
    in_data_req     = '0;
    in_data_we      = 2'b10;
    in_data_be      = {8'hF0, 8'h0F};
    out_data_gnt    = 1'b0;
    out_data_rvalid = 1'b0;
    out_data_rdata  = '0;
    #12;
    chk("rst_out_req", 64'(out_data_req), 64'd0);
    chk("rst_gnt",     64'(in_data_gnt), 64'd0);
    chk("rst_count",   64'(dut.count_q), 64'd0);
    chk("rst_addr",    out_address, 64'd0);
`ifdef MEM_REQ_ARB_ERR_EN
    chk("rst_err", 64'(err_o), 64'd0);
`endif
    rst = 1'b0;

    // Single port read
    tick();
    in_data_req = 2'b01; out_data_gnt = 1'b1;
    #1;
    chk("single_gnt",  64'(in_data_gnt), 64'h1);
    chk("single_addr", out_address, A0);
    chk("single_we",   64'(out_data_we), 64'd0);
    tick();
    chk("single_count1", 64'(dut.count_q), 64'd1);
    in_data_req = 2'b00; out_data_gnt = 1'b0;
    out_data_rvalid = 1'b1; out_data_rdata = 64'hDEAD;
    #1;
    chk("single_rvalid", 64'(in_data_rvalid), 64'h1);
    chk("single_rdata",  in_data_rdata, 64'hDEAD);
    chk("single_idle_req", 64'(out_data_req), 64'd0);
    tick();
    out_data_rvalid = 1'b0;
    #1;
    chk("single_count0", 64'(dut.count_q), 64'd0);

    // Contention, then fill the FIFO
    do_reset();
    in_data_req = 2'b11; out_data_gnt = 1'b1;
    #1;
    chk("cont_gnt0",  64'(in_data_gnt), 64'h1);
    chk("cont_addr0", out_address, A0);
    tick(); #1;
    chk("cont_gnt1",  64'(in_data_gnt), 64'h2);
    chk("cont_addr1", out_address, A1);
    chk("cont_we1",   64'(out_data_we), 64'd1);
    chk("cont_be1",   64'(out_data_be), 64'hF0);
    chk("cont_wd1",   out_data_wdata, 64'hBBBB_0001);
    tick(); #1;
    chk("cont_gnt2", 64'(in_data_gnt), 64'h1);
    tick(); #1;
    chk("cont_gnt3", 64'(in_data_gnt), 64'h2);
    tick(); #1;
    chk("full_count", 64'(dut.count_q), 64'd4);
    chk("full_req",   64'(out_data_req), 64'd0);
    chk("full_gnt",   64'(in_data_gnt), 64'd0);
    chk("full_addr",  out_address, 64'd0);
    out_data_rvalid = 1'b1; out_data_rdata = 64'h11;
    #1;
    chk("full_pop_rvalid", 64'(in_data_rvalid), 64'h1);
    chk("full_pop_req",    64'(out_data_req), 64'd0);
    chk("full_pop_gnt",    64'(in_data_gnt), 64'd0);
    tick();
    out_data_rvalid = 1'b0;
    #1;
    chk("resume_count", 64'(dut.count_q), 64'd3);
    chk("resume_gnt",   64'(in_data_gnt), 64'h1);
    tick();
    // Drain: remaining order is 1,0,1,0
    in_data_req = 2'b00; out_data_gnt = 1'b0; out_data_rvalid = 1'b1;
    out_data_rdata = 64'hC0;
    #1;
    chk("drain0", 64'(in_data_rvalid), 64'h2);
    tick(); out_data_rdata = 64'hC1; #1;
    chk("drain1", 64'(in_data_rvalid), 64'h1);
    chk("drain1_data", in_data_rdata, 64'hC1);
    tick(); #1;
    chk("drain2", 64'(in_data_rvalid), 64'h2);
    tick(); #1;
    chk("drain3", 64'(in_data_rvalid), 64'h1);
    tick();
    out_data_rvalid = 1'b0;
    #1;
    chk("drain_count", 64'(dut.count_q), 64'd0);

    // Stall: winner and fields stay put while gnt is low
    do_reset();
    in_data_req = 2'b11; out_data_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req",  64'(out_data_req), 64'd1);
      chk("stall_gnt",  64'(in_data_gnt), 64'd0);
      chk("stall_addr", out_address, A0);
      tick();
    end
    out_data_gnt = 1'b1;
    #1;
    chk("stall_rel0", 64'(in_data_gnt), 64'h1);
    tick(); #1;
    chk("stall_rel1", 64'(in_data_gnt), 64'h2);
    tick();
    in_data_req = 2'b00; out_data_gnt = 1'b0;
    #1;
    chk("stall_count", 64'(dut.count_q), 64'd2);

    // Reset with two outstanding, then a spurious response
    do_reset();
    #1;
    chk("rst_mid_count", 64'(dut.count_q), 64'd0);
    out_data_rvalid = 1'b1; out_data_rdata = 64'hBAD;
    #1;
    chk("spur_rvalid", 64'(in_data_rvalid), 64'd0);
    tick();
    out_data_rvalid = 1'b0;
    #1;
    chk("spur_count", 64'(dut.count_q), 64'd0);
`ifdef MEM_REQ_ARB_ERR_EN
    chk("spur_err", 64'(err_o), 64'd1);
    tick(); #1;
    chk("spur_err_sticky", 64'(err_o), 64'd1);
`endif
    in_data_req = 2'b11; out_data_gnt = 1'b1;
    #1;
    chk("post_rst_gnt", 64'(in_data_gnt), 64'h1);
    tick();

    // Ordering: grants 1,0,1 then responses A,B,C
    do_reset();
`ifdef MEM_REQ_ARB_ERR_EN
    #1;
    chk("err_cleared", 64'(err_o), 64'd0);
`endif
    in_data_req = 2'b10; out_data_gnt = 1'b1;
    #1;
    chk("ord_g0", 64'(in_data_gnt), 64'h2);
    tick(); in_data_req = 2'b01; #1;
    chk("ord_g1", 64'(in_data_gnt), 64'h1);
    tick(); in_data_req = 2'b10; #1;
    chk("ord_g2", 64'(in_data_gnt), 64'h2);
    tick();
    in_data_req = 2'b00; out_data_gnt = 1'b0;
    out_data_rvalid = 1'b1; out_data_rdata = 64'hA;
    #1;
    chk("ord_r0", 64'(in_data_rvalid), 64'h2);
    chk("ord_d0", in_data_rdata, 64'hA);
    tick(); out_data_rdata = 64'hB; #1;
    chk("ord_r1", 64'(in_data_rvalid), 64'h1);
    chk("ord_d1", in_data_rdata, 64'hB);
    tick(); out_data_rdata = 64'hC; #1;
    chk("ord_r2", 64'(in_data_rvalid), 64'h2);
    chk("ord_d2", in_data_rdata, 64'hC);
    tick(); #1;
    chk("ord_empty_rvalid", 64'(in_data_rvalid), 64'd0);
    out_data_rvalid = 1'b0;
    tick(); #1;
    chk("ord_count", 64'(dut.count_q), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised N-to-1 arbiter for the core's req/gnt/rvalid memory protocol.
- Up to NUM_PORTS masters share one slave-side memory port.
- Round-robin selection on the request path; an in-order ID FIFO routes each rvalid/rdata back to the issuing master.
- Supports up to MAX_OUTSTANDING granted transactions awaiting response. Sits between core-side memory clients (fetch, LSU, PTW) and a single memory/cache port.

Parameters:
- NUM_PORTS, 2, number of master ports (≥2).
- ADDRESS_SIZE, 64, address width.
- DATA_WIDTH, 64, data width (multiple of 8).
- MAX_OUTSTANDING, 4, ID FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_address  in  NUM_PORTS*ADDRESS_SIZE  per-port address; port i at slice [i*ADDRESS_SIZE +: ADDRESS_SIZE].
- in_data_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- in_data_req  in  NUM_PORTS  per-port request.
- in_data_we  in  NUM_PORTS  per-port write enable.
- in_data_be  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enable.
- in_data_gnt  out  NUM_PORTS  per-port grant, one-hot or zero.
- in_data_rvalid  out  NUM_PORTS  per-port response valid, one-hot or zero.
- in_data_rdata  out  DATA_WIDTH  response data, broadcast to all ports.
- out_address  out  ADDRESS_SIZE  slave-side address.
- out_data_wdata  out  DATA_WIDTH  slave-side write data.
- out_data_req  out  1  slave-side request.
- out_data_we  out  1  slave-side write enable.
- out_data_be  out  DATA_WIDTH/8  slave-side byte enable.
- out_data_gnt  in  1  slave-side grant.
- out_data_rvalid  in  1  slave-side response valid.
- out_data_rdata  in  DATA_WIDTH  slave-side response data.

Behaviour:
- Registered state:
  - rr_q, round-robin pointer, $clog2(NUM_PORTS) bits.
  - ID FIFO: MAX_OUTSTANDING entries of port index, with wr_ptr, rd_ptr and a count of $clog2(MAX_OUTSTANDING)+1 bits.
  - Async reset: rr_q=0, FIFO empty, all pointers 0.
- Winner: the first requesting port found scanning from rr_q upward, wrapping modulo NUM_PORTS.
- Request path is combinational, zero latency:
  - out_data_req = |in_data_req && !fifo_full.
  - out_address, out_data_wdata, out_data_we and out_data_be come from the winner.
  - When out_data_req=0, out_* data fields are driven 0.
- in_data_gnt[winner] = out_data_gnt && out_data_req; all other gnt bits are 0.
- Handshake: out_data_req && out_data_gnt.
  - Pushes the winner index into the FIFO.
  - Sets rr_q <= (winner+1) mod NUM_PORTS.
  - With no handshake, rr_q holds even while requests are pending. This gives a stable winner until granted, so a master holding req never sees its selected fields change underneath it.
- Every granted transaction, read or write, yields exactly one out_data_rvalid, returned in order.
- Response path is combinational, zero latency:
  - in_data_rvalid[head] = out_data_rvalid && !fifo_empty.
  - in_data_rdata = out_data_rdata, unconditionally.
  - Any rvalid pops the FIFO.
- Full boundary: when count == MAX_OUTSTANDING, out_data_req=0 and all gnt=0. This holds even if a pop occurs the same cycle; no bypass.
- Simultaneous push and pop with FIFO not full: count unchanged, both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- out_data_rvalid while FIFO empty: dropped, no state change.
- Reset mid-operation: FIFO flushed, outstanding responses forgotten. Any rvalid arriving after reset is dropped under the empty-FIFO rule.

Optional Feature:
- MEM_REQ_ARB_ERR_EN.
- Defined:
  - Adds output port err_o, 1 bit, reset 0.
  - err_o is sticky: set on the clock edge following out_data_rvalid with an empty FIFO.
  - Cleared only by rst.
- Undefined: the port does not exist; spurious rvalid is silently dropped.

Test Plan:
- Single port: port0 requests a read to 0x1000, out_gnt=1 → same-cycle in_gnt=2'b01, FIFO count 1. Next cycle out_rvalid=1 with rdata 0xDEAD → in_rvalid=2'b01, in_rdata=0xDEAD, count 0.
- Contention: ports 0 and 1 both hold req, out_gnt always 1 → grants alternate 01,10,01,10; rr_q toggles each cycle.
- Stall: both req, out_gnt=0 for 3 cycles → winner stays port0, out_address stable, in_gnt=0. Release gnt → port0 granted, then port1.
- Full: MAX_OUTSTANDING=4, 4 grants with no rvalid → 5th cycle out_req=0, in_gnt=0. One rvalid that cycle → still no grant; grant resumes the next cycle.
- Ordering: grants to ports 1,0,1, then three rvalids with rdata A,B,C → in_rvalid sequence 10,01,10 carrying A,B,C.
- Reset with 2 outstanding, then a spurious rvalid → in_rvalid=0, gnt resumes from port0. With MEM_REQ_ARB_ERR_EN defined, err_o=1 from the next edge.
